// File: rtl/mops_sdo_responder.sv
// mops_sdo_responder: CANopen SDO expedited-upload responder for a MOPS-style node.
// Accepts one request frame at a time, decodes it and answers with either an expedited upload
// (index 0x1000 device type, or 0x2400 ADC channel read) or an SDO abort. Requests not
// addressed to this node, or RTR frames, are dropped without a response.
//
// Optional feature: define MOPS_SIGN_ON_EN to emit the NMT boot-up frame (COB 0x700+NODE_ID)
// after reset, before the first request is accepted. Without it, reset exits straight to IDLE.
//
// Ports:
//   clk        in   bus-side clock
//   rst        in   synchronous reset, active-high
//   req_frame  in   [75:65] COB-ID, [64] RTR, [63:0] bytes 0..7 (byte0 = [63:56])
//   req_valid  in   req_frame valid
//   req_ready  out  high only in IDLE
//   adc_ch     out  ADC channel being requested
//   adc_req    out  level request, held for the whole ADC wait
//   adc_ack    in   one-cycle strobe, adc_data valid
//   adc_data   in   ADC result
//   rsp_frame  out  response frame, same layout as req_frame
//   rsp_valid  out  response valid, held until rsp_ready
//   rsp_ready  in   downstream accepts the response
//   busy       out  high in any state other than IDLE
module mops_sdo_responder #(
  parameter logic [6:0]  NODE_ID     = 7'h01,
  parameter int unsigned ADC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [75:0] req_frame,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [4:0]  adc_ch,
  output logic        adc_req,
  input  logic        adc_ack,
  input  logic [15:0] adc_data,
  output logic [75:0] rsp_frame,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        busy
);

  localparam logic [10:0] CobRx   = 11'h600 + {4'b0, NODE_ID};
  localparam logic [10:0] CobTx   = 11'h580 + {4'b0, NODE_ID};
  localparam logic [10:0] CobBoot = 11'h700 + {4'b0, NODE_ID};
  // Last counter value of the ADC wait window; the wait lasts ADC_TIMEOUT cycles.
  localparam logic [7:0]  TmoLast = 8'(ADC_TIMEOUT - 1);

  localparam logic [31:0] AbortCmd     = 32'h0504_0001;
  localparam logic [31:0] AbortSubIdx  = 32'h0609_0011;
  localparam logic [31:0] AbortNoObj   = 32'h0602_0000;
  localparam logic [31:0] AbortTimeout = 32'h0800_0000;
  localparam logic [31:0] DeviceType   = 32'h0000_0191;

  typedef enum logic [2:0] {
    StBoot    = 3'd0,
    StIdle    = 3'd1,
    StDecode  = 3'd2,
    StAdcWait = 3'd3,
    StSend    = 3'd4
  } state_e;

`ifdef MOPS_SIGN_ON_EN
  localparam state_e RstState = StBoot;
  localparam logic   RstBusy  = 1'b1;
`else
  localparam state_e RstState = StIdle;
  localparam logic   RstBusy  = 1'b0;
`endif

  // Build a response frame; data bytes go out LSB first in bytes 4..7.
  function automatic logic [75:0] mk_frame(logic [10:0] cob, logic [7:0] cmd, logic [23:0] mux,
                                           logic [31:0] data);
    return {cob, 1'b0, cmd, mux, data[7:0], data[15:8], data[23:16], data[31:24]};
  endfunction

  state_e      state_q, state_d;
  logic [75:0] req_q, req_d;
  logic [75:0] rsp_frame_q, rsp_frame_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [4:0]  adc_ch_q, adc_ch_d;
  logic        adc_req_q, adc_req_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic [7:0]  cnt_q, cnt_d;

  // Fields of the latched request.
  logic [10:0] rq_cob;
  logic        rq_rtr;
  logic [7:0]  rq_cmd;
  logic [23:0] rq_mux;
  logic [15:0] rq_index;
  logic [7:0]  rq_sub;

  assign rq_cob   = req_q[75:65];
  assign rq_rtr   = req_q[64];
  assign rq_cmd   = req_q[63:56];
  assign rq_mux   = req_q[55:32];
  assign rq_index = {req_q[47:40], req_q[55:48]};
  assign rq_sub   = req_q[39:32];

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_frame_d = rsp_frame_q;
    rsp_valid_d = rsp_valid_q;
    adc_ch_d    = adc_ch_q;
    cnt_d       = '0;

    unique case (state_q)
      StBoot: begin
`ifdef MOPS_SIGN_ON_EN
        if (!rsp_valid_q) begin
          rsp_frame_d = {CobBoot, 1'b0, 64'h0};
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end

      StIdle: begin
        if (req_valid && req_ready_q) begin
          req_d   = req_frame;
          state_d = StDecode;
        end
      end

      StDecode: begin
        if (rq_cob != CobRx || rq_rtr) begin
          state_d = StIdle;
        end else if (rq_cmd != 8'h40) begin
          rsp_frame_d = mk_frame(CobTx, 8'h80, rq_mux, AbortCmd);
          rsp_valid_d = 1'b1;
          state_d     = StSend;
        end else if (rq_index == 16'h1000) begin
          rsp_frame_d = mk_frame(CobTx, 8'h43, rq_mux, DeviceType);
          rsp_valid_d = 1'b1;
          state_d     = StSend;
        end else if (rq_index == 16'h2400) begin
          if (rq_sub <= 8'h1F) begin
            adc_ch_d = rq_sub[4:0];
            state_d  = StAdcWait;
          end else begin
            rsp_frame_d = mk_frame(CobTx, 8'h80, rq_mux, AbortSubIdx);
            rsp_valid_d = 1'b1;
            state_d     = StSend;
          end
        end else begin
          rsp_frame_d = mk_frame(CobTx, 8'h80, rq_mux, AbortNoObj);
          rsp_valid_d = 1'b1;
          state_d     = StSend;
        end
      end

      StAdcWait: begin
        cnt_d = cnt_q + 8'd1;
        // An ack landing in the expiry cycle still produces the data response.
        if (adc_ack) begin
          rsp_frame_d = mk_frame(CobTx, 8'h43, rq_mux, {16'h0, adc_data});
          rsp_valid_d = 1'b1;
          state_d     = StSend;
        end else if (cnt_q == TmoLast) begin
          rsp_frame_d = mk_frame(CobTx, 8'h80, rq_mux, AbortTimeout);
          rsp_valid_d = 1'b1;
          state_d     = StSend;
        end
      end

      StSend: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Status outputs are registered from the next state so they line up with state_q.
    req_ready_d = (state_d == StIdle);
    adc_req_d   = (state_d == StAdcWait);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RstState;
      req_q       <= '0;
      rsp_frame_q <= '0;
      rsp_valid_q <= 1'b0;
      adc_ch_q    <= '0;
      adc_req_q   <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= RstBusy;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_frame_q <= rsp_frame_d;
      rsp_valid_q <= rsp_valid_d;
      adc_ch_q    <= adc_ch_d;
      adc_req_q   <= adc_req_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign adc_ch    = adc_ch_q;
  assign adc_req   = adc_req_q;
  assign rsp_frame = rsp_frame_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule
